// File: rtl/uart_pkg.sv
// Shared constants and drain FSM state type for the UART transmit path.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'd13;
  localparam logic [7:0] ASCII_LF = 8'd10;
  localparam int CLKS_PER_BIT = 10416;

  typedef enum logic [1:0] {
    TXQ_IDLE,
    TXQ_WAIT_START,
    TXQ_WAIT_DONE
  } txq_state_t;

endpackage

// File: rtl/txq_fifo_mem.sv
// Register-array byte FIFO with a level counter.
// Accepts up to two writes and one read per cycle.
module txq_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_cnt,
  input  logic [7:0]        wr_d0,
  input  logic [7:0]        wr_d1,
  input  logic              rd_en,
  output logic [7:0]        head,
  output logic [ADDR_W:0]   level
);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr1;

  assign wr_ptr1 = wr_ptr + 1'b1;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(wr_cnt);
      rd_ptr <= rd_ptr + ADDR_W'(rd_en);
      level  <= level + (ADDR_W+1)'(wr_cnt)
                      - (ADDR_W+1)'(rd_en);
    end
  end

  // Storage needs no reset; level alone says what is valid.
  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) mem[wr_ptr]  <= wr_d0;
    if (wr_cnt == 2'd2) mem[wr_ptr1] <= wr_d1;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue and drain FSM feeding uart_tx.
// Define UART_TXQ_CRLF_EN to expand each LF push into CR+LF.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              tx_start,
  output logic [7:0]        tx_din,
  input  logic              tx_active,
  input  logic              tx_done
);

  txq_state_t  state;
  logic        pop;
  logic        drop;
  logic [1:0]  wr_cnt;
  logic [7:0]  d0;
  logic [7:0]  d1;
  logic [7:0]  head;

  assign full  = (level == (ADDR_W+1)'(DEPTH));
  assign empty = (level == '0);
  assign pop   = (state == TXQ_IDLE) && !empty
              && !tx_active;

  // Capacity is judged on the pre-pop level.
  always_comb begin
    wr_cnt = 2'd0;
    drop   = 1'b0;
    d0     = wr_data;
    d1     = wr_data;
    if (wr_en) begin
      if (full) drop   = 1'b1;
      else      wr_cnt = 2'd1;
`ifdef UART_TXQ_CRLF_EN
      if (wr_data == ASCII_LF) begin
        d0 = ASCII_CR;
        if (level <= (ADDR_W+1)'(DEPTH - 2)) begin
          wr_cnt = 2'd2;
          drop   = 1'b0;
        end else begin
          wr_cnt = 2'd0;
          drop   = 1'b1;
        end
      end
`endif
    end
  end

  txq_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .rst    (rst),
    .wr_cnt (wr_cnt),
    .wr_d0  (d0),
    .wr_d1  (d1),
    .rd_en  (pop),
    .head   (head),
    .level  (level)
  );

  // IDLE ignores tx_done, so a frame left over from before reset is harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TXQ_IDLE;
      tx_start <= 1'b0;
      tx_din   <= 8'h00;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      tx_start <= 1'b0;
      unique case (state)
        TXQ_IDLE: begin
          if (pop) begin
            tx_din   <= head;
            tx_start <= 1'b1;
            state    <= TXQ_WAIT_START;
          end
        end
        TXQ_WAIT_START: begin
          if (tx_done)        state <= TXQ_IDLE;
          else if (tx_active) state <= TXQ_WAIT_DONE;
        end
        TXQ_WAIT_DONE: begin
          if (tx_done) state <= TXQ_IDLE;
        end
        default: state <= TXQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue with a behavioural uart_tx model.
// Sent bytes are scored against a queue of expected bytes.
module tb_uart_tx_queue;

  localparam int BIT   = 4;
  localparam int FRAME = 10 * BIT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       hold = 1'b0;
  logic       full, empty, overflow, tx_start;
  logic [4:0] level;
  logic [7:0] tx_din;
  logic       tx_active, tx_done;

  logic       m_active = 1'b0;
  logic       m_chk = 1'b0;
  logic [7:0] m_byte = 8'h00;
  int         m_cnt = 0;
  int         n_start = 0;
  int         n_done = 0;
  int         passed = 0;
  int         total = 0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] d;
    logic [4:0] lvl;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vec [17];

  always #5 clk = ~clk;

  assign tx_active = m_active | hold;

  uart_tx_queue dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .tx_start  (tx_start),
    .tx_din    (tx_din),
    .tx_active (tx_active),
    .tx_done   (tx_done)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  // uart_tx model: one frame of FRAME cycles per start.
  initial tx_done = 1'b0;
  always @(posedge clk) begin
    tx_done <= 1'b0;
    if (rst) m_chk <= 1'b0;
    if (!m_active) begin
      if (tx_start) begin
        m_active <= 1'b1;
        m_byte   <= tx_din;
        m_cnt    <= FRAME - 1;
        m_chk    <= 1'b1;
        if (exp_q.size() == 0)
          check("extra_start", exp_q.size(), 1);
        else
          check("rx_byte", tx_din, exp_q.pop_front());
      end
    end else if (m_cnt == 0) begin
      m_active <= 1'b0;
      tx_done  <= 1'b1;
      n_done++;
      if (m_chk) check("din_hold", tx_din, m_byte);
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && tx_start) begin
      n_start++;
      check("start_while_busy", tx_active, 0);
    end
  end

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_active || !empty)
           && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 17; i++) begin
      vec[i].d    = 8'h41 + 8'(i);
      vec[i].lvl  = (i < 16) ? 5'(i + 1) : 5'd16;
      vec[i].full = (i >= 15);
      vec[i].ovf  = (i == 16);
    end

    repeat (2) @(negedge clk);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_start", tx_start, 0);
    check("rst_din", tx_din, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // single byte, idle uart
    exp_q.push_back(8'h41);
    push(8'h41);
    check("t1_level1", level, 1);
    check("t1_nostart", tx_start, 0);
    @(negedge clk);
    check("t1_start", tx_start, 1);
    check("t1_din", tx_din, 8'h41);
    check("t1_level0", level, 0);
    check("t1_empty", empty, 1);
    @(negedge clk);
    check("t1_pulse", tx_start, 0);
    drain("t1_drain");

    // fill while uart held busy
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      if (!vec[i].ovf) exp_q.push_back(vec[i].d);
      push(vec[i].d);
      check("t2_level", level, vec[i].lvl);
      check("t2_full", full, vec[i].full);
      check("t2_ovf", overflow, vec[i].ovf);
    end
    @(negedge clk);
    check("t2_ovf_end", overflow, 0);
    check("t2_level16", level, 16);

    hold = 1'b0;
    drain("t3_drain");
    check("t3_order_all", exp_q.size(), 0);
    check("t3_start_done", n_start, n_done);

    // push coinciding with pop at level 5
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'h61 + 8'(i));
      push(8'h61 + 8'(i));
    end
    check("t4_level5", level, 5);
    exp_q.push_back(8'h66);
    hold = 1'b0;
    push(8'h66);
    check("t4_same", level, 5);
    check("t4_start", tx_start, 1);
    check("t4_din", tx_din, 8'h61);
    drain("t4_drain");

    // reset mid-frame with three queued
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h71 + 8'(i));
      push(8'h71 + 8'(i));
    end
    begin
      int n = 0;
      while (!m_active && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("t5_active", m_active, 1);
    end
    repeat (2) @(negedge clk);
    check("t5_level3", level, 3);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t5_level", level, 0);
    check("t5_empty", empty, 1);
    check("t5_full", full, 0);
    check("t5_start", tx_start, 0);
    check("t5_din", tx_din, 8'h00);
    check("t5_ovf", overflow, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h77);
    push(8'h77);
    check("t5_wait_stale", level, 1);
    drain("t5_drain");

`ifdef UART_TXQ_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    push(8'h0A);
    check("t6_crlf_level", level, 2);
    drain("t6_drain");
    hold = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      push(8'h30 + 8'(i));
    end
    push(8'h0A);
    check("t6_lf_ovf", overflow, 1);
    check("t6_lf_level", level, 15);
`else
    exp_q.push_back(8'h0A);
    push(8'h0A);
    check("t6_lf_level", level, 1);
    drain("t6_drain");
    hold = 1'b1;
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(8'h30 + 8'(i));
      push(8'h30 + 8'(i));
    end
    exp_q.push_back(8'h0A);
    push(8'h0A);
    check("t6_lf_ovf", overflow, 0);
    check("t6_lf_level", level, 16);
`endif
    hold = 1'b0;
    drain("t6_drain2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
